viterbi_decoder: RTL and testbench

Hard-decision Viterbi decoder for the rate-1/2, constraint-length-3 convolutional code produced by the channel encoder, with generators g0 = 111 and g1 = 101. It accepts one 2-bit code symbol per valid cycle and runs add-compare-select over the 4 trellis states. Survivor paths are held as a register-exchange of depth TB_DEPTH, and the decoder emits one decoded data bit per accepted symbol after a fixed latency. It sits on the receive side, after the symbol deserializer, and delivers recovered data to the sink.

---
 rtl/viterbi_decoder.sv | 136 +++++++++++++
 tb/tb_viterbi_decoder.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/viterbi_decoder.sv
// viterbi_decoder: hard-decision Viterbi decoder for the rate-1/2, K=3
// convolutional code (g0 = 111, g1 = 101). Four-state add-compare-select
// with saturating, normalized path metrics and a register-exchange survivor
// memory of depth TB_DEPTH. One decoded bit leaves per accepted symbol once
// the survivor memory has filled.
//
// Optional feature macro: VITERBI_ERRCNT_EN adds the err_count port, which
// accumulates the per-symbol minimum metric (an estimate of channel errors).
//
// Handshake: in_valid qualifies sym_in for one cycle and every valid symbol
// is accepted (no ready); out_valid is a one-cycle pulse qualifying data_out.

module viterbi_decoder #(
  parameter int TB_DEPTH = 15,
  parameter int PM_W     = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  input  logic [1:0]  sym_in,
`ifdef VITERBI_ERRCNT_EN
  output logic [15:0] err_count,
`endif
  output logic        out_valid,
  output logic        data_out
);

  localparam int FC_W = $clog2(TB_DEPTH + 1);
  localparam logic [PM_W-1:0] PM_MAX  = '1;
  localparam logic [PM_W-1:0] PM_BIAS = {1'b1, {(PM_W-1){1'b0}}};

  // Path metrics and survivors. The stored survivor omits its oldest bit:
  // that bit only ever feeds data_out, taken from the freshly exchanged path.
  logic [PM_W-1:0]     pm   [4];
  logic [TB_DEPTH-2:0] path [4];
  logic [FC_W-1:0]     fcnt;

  logic [PM_W-1:0]     cand     [4];
  logic [TB_DEPTH-1:0] new_path [4];
  logic [PM_W-1:0]     m_min;
  logic [1:0]          best;
  logic [FC_W-1:0]     fcnt_next;

  // Hamming distance between two 2-bit symbols.
  function automatic logic [1:0] ham(input logic [1:0] a, input logic [1:0] b);
    logic [1:0] x;
    x = a ^ b;
    return {1'b0, x[0]} + {1'b0, x[1]};
  endfunction

  // Metric plus branch metric, clipped at the largest storable value.
  function automatic logic [PM_W-1:0] sat_add(input logic [PM_W-1:0] a,
                                              input logic [1:0] b);
    logic [PM_W:0] sum;
    sum = {1'b0, a} + {{(PM_W-1){1'b0}}, b};
    return sum[PM_W] ? PM_MAX : sum[PM_W-1:0];
  endfunction

  // ACS for all four next states, minimum search, best-state pick, exchange.
  always_comb begin
    logic [1:0]      nsv;
    logic [1:0]      p0;
    logic [1:0]      p1;
    logic [1:0]      wsel;
    logic [PM_W-1:0] c0;
    logic [PM_W-1:0] c1;
    logic            d;
    for (int ns = 0; ns < 4; ns++) begin
      nsv = 2'(ns);
      d   = nsv[0];
      p0  = {1'b0, nsv[1]};
      p1  = {1'b1, nsv[1]};
      // Expected symbol {d^s1, d^s0^s1}; s0 of both predecessors is nsv[1].
      c0  = sat_add(pm[p0], ham(sym_in, {d,        d ^ nsv[1]}));
      c1  = sat_add(pm[p1], ham(sym_in, {d ^ 1'b1, d ^ nsv[1] ^ 1'b1}));
      // Ties favour the predecessor whose s1 is 0.
      if (c1 < c0) begin
        cand[ns] = c1;
        wsel     = p1;
      end else begin
        cand[ns] = c0;
        wsel     = p0;
      end
      new_path[ns] = {path[wsel], d};
    end

    m_min = cand[0];
    for (int i = 1; i < 4; i++) begin
      if (cand[i] < m_min) m_min = cand[i];
    end

    // Lowest-index state that reaches the minimum.
    best = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (cand[i] == m_min) best = 2'(i);
    end

    fcnt_next = (fcnt == FC_W'(TB_DEPTH)) ? fcnt : fcnt + 1'b1;
  end

  // Metric/survivor update, fill counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pm[0] <= '0;
      for (int i = 1; i < 4; i++) pm[i] <= PM_BIAS;
      for (int i = 0; i < 4; i++) path[i] <= '0;
      fcnt      <= '0;
      out_valid <= 1'b0;
      data_out  <= 1'b0;
    end else if (in_valid) begin
      for (int i = 0; i < 4; i++) begin
        pm[i]   <= cand[i] - m_min;
        path[i] <= new_path[i][TB_DEPTH-2:0];
      end
      fcnt      <= fcnt_next;
      out_valid <= (fcnt_next == FC_W'(TB_DEPTH));
      data_out  <= new_path[best][TB_DEPTH-1];
    end else begin
      out_valid <= 1'b0;
    end
  end

`ifdef VITERBI_ERRCNT_EN
  // Accumulate the per-symbol minimum metric, saturating at 16'hFFFF.
  always_ff @(posedge clk) begin
    logic [16:0] acc;
    acc = {1'b0, err_count} + 17'(m_min);
    if (!reset) begin
      err_count <= '0;
    end else if (in_valid) begin
      err_count <= acc[16] ? 16'hFFFF : acc[15:0];
    end
  end
`endif

endmodule

// File: tb/tb_viterbi_decoder.sv
// tb_viterbi_decoder: scoreboard bench for viterbi_decoder. A reference
// encoder produces code symbols; the source data bits are queued and popped
// as decoded bits appear.

module tb_viterbi_decoder;

  localparam int TB_DEPTH = 15;
  localparam int PM_W     = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        in_valid = 1'b0;
  logic [1:0]  sym_in = 2'b00;
  logic        out_valid;
  logic        data_out;
`ifdef VITERBI_ERRCNT_EN
  logic [15:0] err_count;
`endif

  viterbi_decoder #(.TB_DEPTH(TB_DEPTH), .PM_W(PM_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .sym_in    (sym_in),
`ifdef VITERBI_ERRCNT_EN
    .err_count (err_count),
`endif
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  logic [0:0]  exp_q[$];
  logic        data_buf[$];
  logic [1:0]  err_buf[$];
  int          n_checks = 0;
  int          n_errors = 0;
  int          n_acc = 0;
  int          n_out = 0;
  logic        sb_on = 1'b1;
  logic        chk_pm0 = 1'b0;
  logic        chk_norm = 1'b0;
  logic        hold_edge = 1'b0;
  logic        data_prev = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [PM_W-1:0] pm_min();
    logic [PM_W-1:0] m;
    m = dut.pm[0];
    for (int i = 1; i < 4; i++) if (dut.pm[i] < m) m = dut.pm[i];
    return m;
  endfunction

  // Edges with reset released and no symbol must leave the outputs alone.
  always @(posedge clk) hold_edge <= reset && !in_valid;

  // ---------------- monitor ----------------
  always @(negedge clk) begin
    logic [0:0] e;
    if (out_valid) begin
      n_out++;
      check("latency", 32'(n_acc >= TB_DEPTH), 32'd1);
      if (sb_on) begin
        if (exp_q.size() == 0) begin
          check("sb_empty", 32'(exp_q.size()), 32'd1);
        end else begin
          e = exp_q.pop_front();
          check("data", 32'(data_out), 32'(e));
        end
      end
    end
    if (hold_edge) begin
      check("gap_valid", 32'(out_valid), 32'd0);
      check("gap_hold", 32'(data_out), 32'(data_prev));
    end
    data_prev = data_out;
    if (chk_pm0) check("pm0", 32'(dut.pm[0]), 32'd0);
    if (chk_norm) check("pm_norm", 32'(pm_min()), 32'd0);
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset(input logic keep_valid);
    @(negedge clk);
    reset    = 1'b0;
    in_valid = keep_valid;
    @(posedge clk);
    #1;
    n_acc = 0;
    n_out = 0;
    exp_q.delete();
    @(negedge clk);
    reset    = 1'b1;
    in_valid = 1'b0;
  endtask

  task automatic drive_sym(input logic [1:0] s, input logic d);
    @(negedge clk);
    in_valid = 1'b1;
    sym_in   = s;
    if (sb_on) exp_q.push_back(d);
    @(posedge clk);
    n_acc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      sym_in   = 2'(($urandom_range(0, 3)));
      @(posedge clk);
    end
  endtask

  // Encode data_buf (first nsym bits) with the reference encoder, apply the
  // error masks in err_buf, and drive with `gap` idle cycles after each one.
  task automatic send_stream(input int nsym, input int gap);
    logic s0, s1, d;
    logic [1:0] s;
    s0 = 1'b0;
    s1 = 1'b0;
    for (int i = 0; i < nsym; i++) begin
      d = data_buf[i];
      s = {d ^ s1, d ^ s0 ^ s1} ^ err_buf[i];
      s1 = s0;
      s0 = d;
      drive_sym(s, d);
      if (gap > 0) idle(gap);
    end
  endtask

  task automatic load(input logic [5:0] head, input int nhead, input logic fill, input int total);
    data_buf.delete();
    err_buf.delete();
    for (int i = 0; i < total; i++) begin
      data_buf.push_back(i < nhead ? head[nhead-1-i] : fill);
      err_buf.push_back(2'b00);
    end
  endtask

  task automatic finish_stream(input string tag, input int nsym);
    idle(3);
    check({tag, "_count"}, 32'(n_out), 32'(nsym - TB_DEPTH + 1));
    check({tag, "_left"}, 32'(exp_q.size()), 32'(TB_DEPTH - 1));
  endtask

  // ---------------- stimulus ----------------
  localparam int NS = 29;

  initial begin
    do_reset(1'b0);
    // Reset state
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_data", 32'(data_out), 32'd0);
    check("rst_pm0", 32'(dut.pm[0]), 32'd0);
    check("rst_pm1", 32'(dut.pm[1]), 32'd8);
    check("rst_pm3", 32'(dut.pm[3]), 32'd8);
`ifdef VITERBI_ERRCNT_EN
    check("rst_err", 32'(err_count), 32'd0);
`endif

    // Error-free stream: 1,0,1,1,0,0 then zero padding
    load(6'b101100, 6, 1'b0, NS);
    send_stream(NS, 0);
    finish_stream("clean", NS);
`ifdef VITERBI_ERRCNT_EN
    check("clean_err", 32'(err_count), 32'd0);
`endif

    // Third symbol (00) received as 01
    do_reset(1'b0);
    load(6'b101100, 6, 1'b0, NS);
    err_buf[2] = 2'b01;
    send_stream(NS, 0);
    finish_stream("err1", NS);
`ifdef VITERBI_ERRCNT_EN
    check("err1_err", 32'(err_count), 32'd1);
`endif

    // Three idle cycles between every pair of symbols
    do_reset(1'b0);
    load(6'b101100, 6, 1'b0, NS);
    send_stream(NS, 3);
    finish_stream("gaps", NS);

    // Reset after 8 symbols (with in_valid high), then the full stream
    do_reset(1'b0);
    load(6'b101100, 6, 1'b0, NS);
    send_stream(8, 0);
    check("pre_rst_out", 32'(n_out), 32'd0);
    do_reset(1'b1);
    send_stream(NS, 0);
    finish_stream("rerun", NS);

    // All-zero stream of 40 symbols
    do_reset(1'b0);
    load(6'b000000, 0, 1'b0, 40);
    chk_pm0 = 1'b1;
    send_stream(40, 0);
    finish_stream("zeros", 40);
    chk_pm0 = 1'b0;
`ifdef VITERBI_ERRCNT_EN
    check("zeros_err", 32'(err_count), 32'd0);
`endif

    // All-ones data with two adjacent symbol errors, then zero padding
    do_reset(1'b0);
    load(6'b111111, 6, 1'b1, 50);
    for (int i = 30; i < 50; i++) data_buf[i] = 1'b0;
    err_buf[10] = 2'b01;
    err_buf[11] = 2'b10;
    send_stream(50, 0);
    finish_stream("ones", 50);
`ifdef VITERBI_ERRCNT_EN
    check("ones_err_ge2", 32'(err_count >= 16'd2), 32'd1);
    check("ones_err_nowrap", 32'(err_count < 16'd100), 32'd1);
`endif

    // Random symbols: metrics stay normalized, output rate holds
    do_reset(1'b0);
    sb_on    = 1'b0;
    chk_norm = 1'b1;
    for (int i = 0; i < 1000; i++) begin
      drive_sym(2'($urandom_range(0, 3)), 1'b0);
      if ($urandom_range(0, 7) == 0) idle(1);
    end
    idle(2);
    chk_norm = 1'b0;
    check("rand_count", 32'(n_out), 32'(1000 - TB_DEPTH + 1));
`ifdef VITERBI_ERRCNT_EN
    check("rand_err_nonzero", 32'(err_count > 16'd0), 32'd1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
